// File: rtl/avalon_lsu_pkg.sv
// Shared types and defaults for the Avalon-MM master load/store unit.
package avalon_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    GAP  = 2'b10
  } lsu_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/avalon_lane_align.sv
// Byte-lane steering for word-aligned buses: byteenable and store-data shifting,
// load-lane extraction with sign/zero extension, and alignment checking.
module avalon_lane_align
  import avalon_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  mem_size_t   sz;
  logic [31:0] rdata_shr;

  assign sz         = mem_size_t'(size);
  assign wdata_lane = wdata << {addr_lo, 3'b000};
  // Half accesses are 2-byte aligned, so the same right shift picks either lane pair.
  assign rdata_shr  = rdata >> {addr_lo, 3'b000};

  always_comb begin
    byteenable = 4'b1111;
    misaligned = 1'b0;
    rdata_ext  = rdata;
    case (sz)
      SZ_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        rdata_ext  = {{24{sign_ext & rdata_shr[7]}}, rdata_shr[7:0]};
      end
      SZ_HALF: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
        rdata_ext  = {{16{sign_ext & rdata_shr[15]}}, rdata_shr[15:0]};
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/avalon_master_lsu.sv
// Avalon-MM master load/store unit: one CPU access at a time, IDLE -> BUS -> GAP.
// Optional macro AVM_TIMEOUT_EN aborts a stalled access after TIMEOUT_CYCLES wait cycles.
module avalon_master_lsu
  import avalon_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  lsu_state_t  state, state_nxt;
  logic        op_write, op_signed, err_pending, timeout;
  logic [1:0]  op_size, op_lo;
  logic [1:0]  al_size, al_lo;
  logic        al_sign, al_mis;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  // In IDLE the aligner sees the incoming request; afterwards the captured one.
  assign al_size = (state == IDLE) ? req_size      : op_size;
  assign al_lo   = (state == IDLE) ? req_addr[1:0] : op_lo;
  assign al_sign = (state == IDLE) ? req_signed    : op_signed;

  avalon_lane_align u_align (
    .size       (al_size),
    .addr_lo    (al_lo),
    .sign_ext   (al_sign),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .byteenable (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

`ifdef AVM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != BUS) begin
      wait_cnt <= '0;
    end else if (waitrequest) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (state == BUS) && waitrequest &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = al_mis ? GAP : BUS;
      BUS:     if (!waitrequest || timeout) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    read      = (state == BUS) && !op_write;
    write     = (state == BUS) && op_write;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      op_write  <= req_write;
      op_size   <= req_size;
      op_lo     <= req_addr[1:0];
      op_signed <= req_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      address     <= '0;
      byteenable  <= '0;
      writedata   <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      err_pending <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            err_pending <= al_mis;
            if (!al_mis) begin
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= al_be;
              writedata  <= al_wdata;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= op_write ? 32'h0 : al_rdata;
          end else if (timeout) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
          end
        end
        GAP: begin
          // Misaligned requests report here so their latency matches a zero-wait access.
          if (err_pending) begin
            resp_valid  <= 1'b1;
            resp_err    <= 1'b1;
            resp_rdata  <= 32'h0;
            err_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_master_lsu.sv
// Self-checking bench for avalon_master_lsu with a waitstate-programmable RAM responder
// and a response scoreboard; the AVM_TIMEOUT_EN build adds the timeout scenario.
module tb_avalon_master_lsu;
  import avalon_lsu_pkg::*;

`ifdef AVM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        read, write, waitrequest;

  always #5 clk = ~clk;

  avalon_master_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .byteenable  (byteenable),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  // Responder: word RAM, 'waits' wait cycles per transfer, counts rising edges of read|write
  logic [31:0] mem [16] = '{0: 32'hDEADBEEF, 1: 32'h8899AABB, 2: 32'h0BADF00D,
                            3: 32'h7F0080FF, default: 32'h0};
  int unsigned waits = 0;
  logic [7:0]  wcnt = 8'd0;
  logic        prev_rw = 1'b0;
  int          rises = 0;
  int          cyc = 0;

  assign waitrequest = (read || write) && (32'(wcnt) < waits);
  assign readdata    = mem[address[5:2]];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_rw <= read || write;
    if ((read || write) && !prev_rw) rises <= rises + 1;
    if (read || write) begin
      if (wcnt != 8'hFF) wcnt <= wcnt + 8'd1;
    end else begin
      wcnt <= 8'd0;
    end
    if (write && !waitrequest) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[address[5:2]][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t sbq[$];

  // Bus/response monitor, sampled on the falling edge
  exp_t       mon_e;
  int         rd_cur = 0, rd_len = 0, rw_cycles = 0, bad_ready = 0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_wd = 32'h0;

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sbq.size() == 0) begin
        check_eq("spurious_resp", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check_eq("resp_rdata", resp_rdata, mon_e.rdata);
        check_eq("resp_err", resp_err, mon_e.err);
        check_eq("resp_cycle", cyc, mon_e.at);
      end
    end
    if (read || write) begin
      rw_cycles++;
      last_be = byteenable;
      last_wd = writedata;
      if (req_ready) bad_ready++;
    end
    if (read) begin
      rd_cur++;
    end else if (rd_cur > 0) begin
      rd_len = rd_cur;
      rd_cur = 0;
    end
  end

  // Called on a falling edge; holds the request until accepted and queues its expectation.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat,
                        output int stalls);
    stalls     = 0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    while (!req_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!req_ready) begin
      check_eq("req_ready_timeout", 0, 1);
    end else begin
      sbq.push_back('{er, ee, cyc + 1 + lat});
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] er;
    logic [3:0]  be;
  } ld_t;

  initial begin
    int st, st2, r0, rw0;
    ld_t loads [5];
    loads[0] = '{SZ_BYTE, 1'b1, 32'hBFC00006, 32'hFFFFFF99, 4'b0100};
    loads[1] = '{SZ_BYTE, 1'b0, 32'hBFC00006, 32'h00000099, 4'b0100};
    loads[2] = '{SZ_HALF, 1'b1, 32'hBFC00006, 32'hFFFF8899, 4'b1100};
    loads[3] = '{SZ_HALF, 1'b0, 32'hBFC00004, 32'h0000AABB, 4'b0011};
    loads[4] = '{SZ_BYTE, 1'b1, 32'hBFC00004, 32'hFFFFFFBB, 4'b0001};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_read", read, 0);
    check_eq("rst_write", write, 0);
    check_eq("rst_address", address, 0);
    check_eq("rst_byteenable", byteenable, 0);
    check_eq("rst_writedata", writedata, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_rdata", resp_rdata, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_req_ready", req_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // Word load with three wait cycles
    waits = 3;
    do_req(1'b0, SZ_WORD, 1'b0, 32'hBFC00004, 32'h0, 32'h8899AABB, 1'b0, 4, st);
    wait_idle();
    check_eq("word_read_len", rd_len, 4);
    check_eq("word_be", last_be, 4'b1111);
    check_eq("word_address", address, 32'hBFC00004);

    // Byte/half loads, signed and unsigned
    waits = 1;
    foreach (loads[i]) begin
      do_req(1'b0, loads[i].sz, loads[i].sg, loads[i].a, 32'h0, loads[i].er, 1'b0, 2, st);
      wait_idle();
      check_eq("load_be", last_be, loads[i].be);
    end

    // Half and byte stores into 0xDEADBEEF
    waits = 2;
    do_req(1'b1, SZ_HALF, 1'b0, 32'hBFC00002, 32'h00001234, 32'h0, 1'b0, 3, st);
    wait_idle();
    check_eq("half_st_be", last_be, 4'b1100);
    check_eq("half_st_wd_hi", last_wd[31:16], 16'h1234);
    check_eq("half_st_mem", mem[0], 32'h1234BEEF);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'hBFC00003, 32'h00000056, 32'h0, 1'b0, 3, st);
    wait_idle();
    check_eq("byte_st_be", last_be, 4'b1000);
    check_eq("byte_st_mem", mem[0], 32'h5634BEEF);

    // Misaligned accesses never touch the bus
    rw0 = rw_cycles;
    do_req(1'b0, SZ_WORD, 1'b0, 32'hBFC00001, 32'h0, 32'h0, 1'b1, 1, st);
    wait_idle();
    do_req(1'b1, SZ_HALF, 1'b0, 32'hBFC00005, 32'hFFFF, 32'h0, 1'b1, 1, st);
    wait_idle();
    check_eq("misalign_no_bus", rw_cycles - rw0, 0);
    check_eq("misalign_mem_kept", mem[1], 32'h8899AABB);

    // Back-to-back zero-wait loads
    waits = 0;
    r0 = rises;
    do_req(1'b0, SZ_WORD, 1'b0, 32'hBFC00008, 32'h0, 32'h0BADF00D, 1'b0, 1, st);
    do_req(1'b0, SZ_WORD, 1'b0, 32'hBFC0000C, 32'h0, 32'h7F0080FF, 1'b0, 1, st2);
    check_eq("b2b_stall", st2, 2);
    wait_idle();
    check_eq("b2b_read_edges", rises - r0, 2);
    check_eq("ready_low_in_bus", bad_ready, 0);

    // Reset while stalled in BUS abandons the access
    waits = 200;
    do_req(1'b0, SZ_WORD, 1'b0, 32'hBFC00004, 32'h0, 32'h0, 1'b0, 0, st);
    repeat (2) @(negedge clk);
    check_eq("stall_read_high", read, 1);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    check_eq("rst_bus_read", read, 0);
    check_eq("rst_bus_resp", resp_valid, 0);
    check_eq("rst_bus_ready", req_ready, 1);
    reset = 1'b0;
    waits = 0;
    repeat (5) @(negedge clk);

`ifdef AVM_TIMEOUT_EN
    // Stuck waitrequest aborts after TIMEOUT_CYCLES wait cycles
    waits = 200;
    do_req(1'b0, SZ_WORD, 1'b0, 32'hBFC00004, 32'h0, 32'h0, 1'b1, TO, st);
    wait_idle();
    check_eq("timeout_read_len", rd_len, TO);
    waits = 0;
`endif

    // Normal access after abort/reset
    do_req(1'b0, SZ_WORD, 1'b0, 32'hBFC00004, 32'h0, 32'h8899AABB, 1'b0, 1, st);
    wait_idle();
    check_eq("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/avalon_master_lsu.md
Name: avalon_master_lsu

Overview:
- Avalon-MM master load/store unit between the MIPS CPU datapath and the memory bus. It is the initiator for the word-addressed RAM responder on that bus.
- Accepts one CPU load/store request at a time and converts byte/half/word accesses into aligned word transfers with byteenable.
- Holds read/write until waitrequest is released, then returns lane-aligned, sign/zero-extended load data.
- Forces one idle cycle between bus transfers, because the responder detects a new request on the rising edge of read/write.

Parameters:
- TIMEOUT_CYCLES, 64, wait cycles before an access is aborted (used only with AVM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request strobe
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1=store, 0=load
- req_size  in  2  access size, encoded as mem_size_t
- req_signed  in  1  sign-extend the load result
- req_addr  in  32  CPU byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  extended load data (0 for stores)
- resp_err  out  1  qualifies resp_valid: misaligned access or timeout
- address  out  32  Avalon word address (bits[1:0]=0)
- byteenable  out  4  Avalon byte lanes
- read  out  1  Avalon read
- write  out  1  Avalon write
- writedata  out  32  lane-shifted store data
- waitrequest  in  1  Avalon stall
- readdata  in  32  Avalon read data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, read=0, write=0, address=0, byteenable=0, writedata=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
- Reset mid-transfer: read/write drop at the next edge; the transfer is abandoned and no resp_valid is issued.
- State IDLE:
  - req_ready=1.
  - On req_valid, register the request.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): go to GAP, pulse resp_valid with resp_err=1 next cycle, no bus access.
  - Otherwise go to BUS with address={addr[31:2],2'b00}.
  - byteenable: byte = 1<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - writedata = wdata shifted left by 8*addr[1:0] (byte/half replicated lanes not required).
- State BUS:
  - read or write held high; all Avalon outputs stable.
  - Transfer completes at the first rising edge with waitrequest=0.
  - Load: capture readdata, extract the selected lane, then extend. Byte lane = readdata[8*a+7:8*a]; half = a[1] ? [31:16] : [15:0]. Extend by req_signed.
  - resp_valid=1 and resp_rdata valid in the cycle after completion. Go to GAP.
  - Zero-wait responder: if waitrequest=0 on the first BUS edge, latency is 1 cycle in BUS; a request accepted at edge N gives resp_valid during cycle N+2.
- State GAP:
  - read=write=0, req_ready=0, for exactly one cycle, then IDLE.
  - Guarantees a rising edge of read/write for every transfer.
- req_valid while req_ready=0 is ignored; the CPU holds the request (stall).
- Back-to-back requests: minimum spacing of 3 cycles (IDLE → BUS → GAP).
- resp_valid is a single-cycle pulse. resp_rdata holds its value until the next response.

Optional Feature:
- Macro: AVM_TIMEOUT_EN.
- Defined:
  - A counter increments each BUS cycle with waitrequest=1.
  - On reaching TIMEOUT_CYCLES: drop read/write, go to GAP, pulse resp_valid with resp_err=1, resp_rdata=0.
  - The counter clears on entry to BUS.
- Undefined: no counter; BUS waits indefinitely; resp_err is asserted only for misalignment.

Decomposition:
- Package avalon_lsu_pkg:
  - mem_size_t enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - lsu_state_t enum: IDLE, BUS, GAP.
  - Default TIMEOUT_CYCLES constant.
- Sub-module avalon_lane_align (combinational):
  - byteenable/writedata generation from size and addr[1:0].
  - Load lane extraction and extension.
  - Reused by the CPU's LWL/LWR path.

Test Plan:
- Word load 0xBFC00004, responder 3 wait cycles, mem word 0x8899AABB → read held 4 cycles, byteenable=4'b1111, resp_rdata=0x8899AABB, one resp_valid pulse.
- Signed byte load 0xBFC00006 from word 0x8899AABB → byteenable=4'b0100, resp_rdata=0xFFFFFF99; unsigned gives 0x00000099.
- Half store 0xBFC00002, wdata=0x1234, old word 0xDEADBEEF → byteenable=4'b1100, writedata[31:16]=0x1234, memory becomes 0x1234BEEF.
- Misaligned word load 0xBFC00001 → read/write never assert, resp_valid with resp_err=1 two cycles after acceptance.
- Two back-to-back loads, zero-wait responder → read low for ≥1 cycle between them, both data correct, req_ready low during BUS and GAP.
- Reset asserted in BUS while waitrequest=1 → read=0 next cycle, no resp_valid; with AVM_TIMEOUT_EN and TIMEOUT_CYCLES=8, a stuck waitrequest gives resp_err=1 after 8 wait cycles.
